// File: rtl/beep_tone_driver.sv
// beep_tone_driver: turns debounced key presses into fixed-length square-wave beeps with a quiet gap and a one-deep pending slot
module beep_tone_driver #(
   parameter int W = 3,
   parameter int BASE_HALF = 100_000,
   parameter int STEP_HALF = 10_000,
   parameter int BEEP_TIME = 10_000_000,
   parameter int GAP_TIME = 2_500_000,
   localparam int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  key_in,
   output logic          beep,
   output logic          busy,
   output logic [IW-1:0] tone_idx
);
   localparam int HW = $clog2(BASE_HALF);
   localparam int DW = $clog2((BEEP_TIME > GAP_TIME) ? BEEP_TIME : GAP_TIME);
   localparam logic [DW-1:0] BEEP_TOP = DW'(BEEP_TIME - 1);
   localparam logic [DW-1:0] GAP_TOP = DW'(GAP_TIME - 1);
   typedef enum logic [2:0] {IDLE = 3'b001, TONE = 3'b010, GAP = 3'b100} state_t;
   state_t state;
   logic [W-1:0] key_r, press;
   logic [IW-1:0] sel, pend_idx;
   logic pend_valid, any_press;
   logic [HW-1:0] half_cnt, half_top;
   logic [DW-1:0] dur_cnt;
   assign press = key_r & ~key_in;
   assign any_press = |press;
   always_comb begin
      sel = '0;
      for (int i = W - 1; i >= 0; i--)
         sel = press[i] ? IW'(i) : sel;
   end
   assign half_top = HW'(BASE_HALF - 1 - STEP_HALF * int'(tone_idx));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         beep <= 1'b0;
         busy <= 1'b0;
         tone_idx <= '0;
         pend_valid <= 1'b0;
         pend_idx <= '0;
         key_r <= '1;
         half_cnt <= '0;
         dur_cnt <= '0;
      end else begin
         key_r <= key_in;
         case (state)
            IDLE: if (any_press) begin
               state <= TONE;
               busy <= 1'b1;
               tone_idx <= sel;
               beep <= 1'b1;
               half_cnt <= '0;
               dur_cnt <= '0;
            end
            TONE: begin
               if (any_press) begin
                  pend_valid <= 1'b1;
                  pend_idx <= sel;
               end
               half_cnt <= (half_cnt == half_top) ? '0 : half_cnt + 1'b1;
               beep <= (half_cnt == half_top) ? ~beep : beep;
               dur_cnt <= dur_cnt + 1'b1;
               // tone end overrides the half-period toggle
               if (dur_cnt == BEEP_TOP) begin
                  state <= GAP;
                  beep <= 1'b0;
                  half_cnt <= '0;
                  dur_cnt <= '0;
               end
            end
            GAP: begin
               dur_cnt <= dur_cnt + 1'b1;
               if (any_press) begin
                  pend_valid <= 1'b1;
                  pend_idx <= sel;
               end
               if (dur_cnt == GAP_TOP) begin
                  half_cnt <= '0;
                  dur_cnt <= '0;
                  pend_valid <= 1'b0;
                  if (any_press || pend_valid) begin
                     state <= TONE;
                     tone_idx <= any_press ? sel : pend_idx;
                     beep <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
               beep <= 1'b0;
            end
         endcase
      end
   end
endmodule
